// File: rtl/req_capture_encoder_if.sv
// req_capture_encoder_if: request/code handshake bundle; mask ports exist only when REQ_MASK_EN is defined
interface req_capture_encoder_if #(
    parameter int N      = 8,
    parameter int CODE_W = 3
);
    logic [N-1:0]      req;
    logic              code_ready;
    logic [CODE_W-1:0] code;
    logic              code_valid;
    logic [N-1:0]      pending;
    logic              overflow;
`ifdef REQ_MASK_EN
    logic [N-1:0]      mask_in;
    logic              mask_we;
    modport master (output req, code_ready, mask_in, mask_we, input code, code_valid, pending, overflow);
    modport slave  (input req, code_ready, mask_in, mask_we, output code, code_valid, pending, overflow);
`else
    modport master (output req, code_ready, input code, code_valid, pending, overflow);
    modport slave  (input req, code_ready, output code, code_valid, pending, overflow);
`endif
endinterface

// File: rtl/req_capture_encoder.sv
// req_capture_encoder: sticky request capture with lowest-index-first encoding on a valid/ready code output; REQ_MASK_EN adds a selection mask
module req_capture_encoder #(
    parameter int N      = 8,
    parameter int CODE_W = 3
) (
    input logic                   clk,
    input logic                   rst,
    req_capture_encoder_if.slave  bus
);
    logic [N-1:0]      pending;
    logic [N-1:0]      mask;
    logic [N-1:0]      elig;
    logic [N-1:0]      clr;
    logic [CODE_W-1:0] sel;
    logic [CODE_W-1:0] code;
    logic              code_valid;
    logic              overflow;
    logic              free;
    logic              load;

`ifdef REQ_MASK_EN
    // mask register: all bits eligible after reset, rewritten on mask_we
    always_ff @(posedge clk) begin
        if (rst) mask <= '1;
        else if (bus.mask_we) mask <= bus.mask_in;
    end
`else
    assign mask = '1;
`endif

    assign elig = pending & mask;

    // lowest set eligible bit wins; scanning downward leaves the smallest index last
    always_comb begin
        sel = '0;
        for (int i = N - 1; i >= 0; i--)
            if (elig[i]) sel = CODE_W'(i);
    end

    assign free = !code_valid || bus.code_ready;
    assign load = free && (|elig);
    assign clr  = load ? ({{(N-1){1'b0}}, 1'b1} << sel) : '0;

    // clear the loaded bit before capturing new requests so a same-edge re-request stays pending
    always_ff @(posedge clk) begin
        if (rst) begin
            pending    <= '0;
            code       <= '0;
            code_valid <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            pending  <= (pending & ~clr) | bus.req;
            overflow <= |(bus.req & pending & ~clr);
            if (free) begin
                code_valid <= load;
                if (load) code <= sel;
            end
        end
    end

    assign bus.code       = code;
    assign bus.code_valid = code_valid;
    assign bus.pending    = pending;
    assign bus.overflow   = overflow;
endmodule

// File: tb/tb_req_capture_encoder.sv
// tb_req_capture_encoder: directed vector table plus hand sequences for latency and (with REQ_MASK_EN) masking
module tb_req_capture_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    req_capture_encoder_if #(.N(8), .CODE_W(3)) bus ();

    req_capture_encoder #(.N(8), .CODE_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r;
        logic [7:0] req;
        logic       rdy;
        logic [2:0] code;
        logic       vld;
        logic [7:0] pend;
        logic       ovf;
    } vec_t;

    vec_t tv[33];

    function automatic vec_t mk(logic r, logic [7:0] req, logic rdy, logic [2:0] code, logic vld, logic [7:0] pend, logic ovf);
        vec_t v;
        v.r = r; v.req = req; v.rdy = rdy; v.code = code; v.vld = vld; v.pend = pend; v.ovf = ovf;
        return v;
    endfunction

    function automatic logic [12:0] pk(logic [2:0] code, logic vld, logic [7:0] pend, logic ovf);
        return {code, vld, pend, ovf};
    endfunction

    task automatic check(input string name, input logic [12:0] exp);
        logic [12:0] got;
        got = {bus.code, bus.code_valid, bus.pending, bus.overflow};
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got code=%0d valid=%0b pending=%h overflow=%0b, expected code=%0d valid=%0b pending=%h overflow=%0b",
                     name, got[12:10], got[9], got[8:1], got[0], exp[12:10], exp[9], exp[8:1], exp[0]);
        end
    endtask

    task automatic drive(input logic r, input logic [7:0] req, input logic rdy);
        rst = r;
        bus.req = req;
        bus.code_ready = rdy;
        @(negedge clk);
    endtask

    initial begin
        int lat;
        bus.req = '0;
        bus.code_ready = 1'b1;
`ifdef REQ_MASK_EN
        bus.mask_in = '1;
        bus.mask_we = 1'b0;
`endif
        tv[0]  = mk(1, 8'h00, 1, 0, 0, 8'h00, 0);
        tv[1]  = mk(1, 8'h00, 1, 0, 0, 8'h00, 0);
        tv[2]  = mk(0, 8'h00, 1, 0, 0, 8'h00, 0);
        tv[3]  = mk(0, 8'h00, 1, 0, 0, 8'h00, 0);
        tv[4]  = mk(0, 8'h20, 1, 0, 0, 8'h20, 0);
        tv[5]  = mk(0, 8'h00, 1, 5, 1, 8'h00, 0);
        tv[6]  = mk(0, 8'h00, 1, 5, 0, 8'h00, 0);
        tv[7]  = mk(0, 8'h85, 1, 5, 0, 8'h85, 0);
        tv[8]  = mk(0, 8'h00, 1, 0, 1, 8'h84, 0);
        tv[9]  = mk(0, 8'h00, 1, 2, 1, 8'h80, 0);
        tv[10] = mk(0, 8'h00, 1, 7, 1, 8'h00, 0);
        tv[11] = mk(0, 8'h00, 1, 7, 0, 8'h00, 0);
        tv[12] = mk(0, 8'h80, 0, 7, 0, 8'h80, 0);
        tv[13] = mk(0, 8'h00, 0, 7, 1, 8'h00, 0);
        tv[14] = mk(0, 8'h02, 0, 7, 1, 8'h02, 0);
        tv[15] = mk(0, 8'h00, 0, 7, 1, 8'h02, 0);
        tv[16] = mk(0, 8'h00, 1, 1, 1, 8'h00, 0);
        tv[17] = mk(0, 8'h00, 1, 1, 0, 8'h00, 0);
        tv[18] = mk(0, 8'h10, 0, 1, 0, 8'h10, 0);
        tv[19] = mk(0, 8'h00, 0, 4, 1, 8'h00, 0);
        tv[20] = mk(0, 8'h08, 0, 4, 1, 8'h08, 0);
        tv[21] = mk(0, 8'h08, 0, 4, 1, 8'h08, 1);
        tv[22] = mk(0, 8'h00, 0, 4, 1, 8'h08, 0);
        tv[23] = mk(0, 8'h00, 1, 3, 1, 8'h00, 0);
        tv[24] = mk(0, 8'h00, 1, 3, 0, 8'h00, 0);
        tv[25] = mk(0, 8'h08, 1, 3, 0, 8'h08, 0);
        tv[26] = mk(0, 8'h08, 1, 3, 1, 8'h08, 0);
        tv[27] = mk(0, 8'h00, 1, 3, 1, 8'h00, 0);
        tv[28] = mk(0, 8'h00, 1, 3, 0, 8'h00, 0);
        tv[29] = mk(0, 8'h06, 0, 3, 0, 8'h06, 0);
        tv[30] = mk(0, 8'h00, 0, 1, 1, 8'h04, 0);
        tv[31] = mk(1, 8'h01, 1, 0, 0, 8'h00, 0);
        tv[32] = mk(0, 8'h00, 1, 0, 0, 8'h00, 0);

        @(negedge clk);
        for (int i = 0; i < 33; i++) begin
            drive(tv[i].r, tv[i].req, tv[i].rdy);
            check($sformatf("vec%0d", i), pk(tv[i].code, tv[i].vld, tv[i].pend, tv[i].ovf));
        end

        drive(0, 8'h40, 1);
        bus.req = '0;
        lat = 1;
        while (!bus.code_valid && lat < 6) begin
            @(negedge clk);
            lat++;
        end
        n_cmp++;
        if (lat != 2) begin
            n_bad++;
            $display("FAIL latency: got %0d cycles, expected 2", lat);
        end
        check("latency_code", pk(6, 1, 8'h00, 0));
        drive(0, 8'h00, 1);
        check("latency_drain", pk(6, 0, 8'h00, 0));

`ifdef REQ_MASK_EN
        bus.mask_in = 8'hFE;
        bus.mask_we = 1'b1;
        drive(0, 8'h00, 0);
        bus.mask_we = 1'b0;
        drive(0, 8'h03, 0);
        check("mask_capture", pk(6, 0, 8'h03, 0));
        drive(0, 8'h00, 0);
        check("mask_load1", pk(1, 1, 8'h01, 0));
        drive(0, 8'h00, 1);
        check("mask_hold0", pk(1, 0, 8'h01, 0));
        drive(0, 8'h00, 1);
        check("mask_still0", pk(1, 0, 8'h01, 0));
        drive(1, 8'h00, 1);
        check("mask_reset", pk(0, 0, 8'h00, 0));
        drive(0, 8'h01, 1);
        check("mask_req0", pk(0, 0, 8'h01, 0));
        drive(0, 8'h00, 1);
        check("mask_ff_after_rst", pk(0, 1, 8'h00, 0));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
